branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Branch history table (BHT) of 2-bit saturating counters, consuming the branch comparator's br_en in EX.
- Gives a taken/not-taken prediction to fetch.
- Trains on each resolved conditional branch and raises a registered redirect on mispredict.
- Keeps saturating performance counters for branches and mispredicts.

Parameters:
- IDX_BITS, 6, BHT index width; 2**IDX_BITS entries, indexed by pc[IDX_BITS+1:2].
- CTR_INIT, 2'b01, reset value of every counter (weakly not-taken).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- if_pc  input  32  fetch-stage PC.
- if_pred_taken  output  1  prediction for if_pc: counter[idx(if_pc)][1]; combinational read of registered array.
- ex_valid  input  1  EX holds a valid instruction.
- ex_is_branch  input  1  EX instruction is a conditional branch (opcode BRANCH).
- ex_stall  input  1  EX held this cycle; suppresses all updates.
- ex_pc  input  32  PC of EX instruction.
- ex_target  input  32  computed branch target (pc + imm_b).
- ex_br_en  input  1  comparator result; 1 = taken.
- ex_pred_taken  input  1  if_pred_taken value carried down the pipe with this instruction.
- redirect_valid  output  1  registered one-cycle pulse: fetch must load redirect_pc, younger stages flush.
- redirect_pc  output  32  correct next PC for the mispredicted branch.
- branch_count  output  32  resolved branches, saturating.
- mispredict_count  output  32  mispredicts, saturating.

Behaviour:
- Reset (rst_n low, async): all counters = CTR_INIT; redirect_valid = 0; redirect_pc = 0; branch_count = 0; mispredict_count = 0. if_pred_taken reflects CTR_INIT[1] = 0 immediately.
- resolve = ex_valid & ex_is_branch & ~ex_stall & ~redirect_valid.
  - EX contents in the cycle redirect_valid is high are wrong-path and ignored.
- Counter training on resolve at idx = ex_pc[IDX_BITS+1:2]:
  - ex_br_en = 1: ctr = (ctr == 2'b11) ? 2'b11 : ctr + 1.
  - ex_br_en = 0: ctr = (ctr == 2'b00) ? 2'b00 : ctr - 1.
  - No other entry changes.
- Mispredict = resolve & (ex_br_en != ex_pred_taken).
- On mispredict, next edge: redirect_valid = 1 for exactly one cycle.
  - redirect_pc = ex_br_en ? ex_target : ex_pc + 4 (32-bit wrap, no carry out).
  - Otherwise redirect_valid = 0 and redirect_pc holds its last value.
- Latency: resolve in cycle N, so counter update and redirect are visible in cycle N+1.
- Same-index read/write in one cycle: if_pred_taken shows the old counter value; no bypass.
- Aliasing: PCs sharing idx share one counter, by design. ex_pc[1:0] is ignored.
- Perf counters on resolve:
  - branch_count += 1.
  - mispredict_count += 1 if mispredict.
  - Both saturate at 32'hFFFF_FFFF.
- Stall: with ex_stall = 1 nothing updates, and the held instruction resolves exactly once, after the stall drops.
- Non-branch or ex_valid = 0: no state change.
- Reset asserted mid-redirect: redirect_valid clears asynchronously; no pending redirect survives.

Decomposition:
- Shared package:
  - bht_ctr_t (logic [1:0]).
  - Constants BHT_SNT = 2'b00, BHT_WNT = 2'b01, BHT_WT = 2'b10, BHT_ST = 2'b11.
  - Function bht_next(ctr, taken) implementing saturation.
  - Reuse existing rv32i_word and opcode types.
- One sub-module: bht_array, holding the counter array.
  - Async read port (if_pc index) and one synchronous write port (idx, we, taken).
  - Async active-low reset to CTR_INIT.
- Redirect, mispredict and perf counters live in the top module.

Test Plan:
- Reset then if_pc = 0x100 -> if_pred_taken = 0. Counters, redirect_valid, branch_count and mispredict_count all 0.
- Resolve branch at ex_pc = 0x100, br_en = 1, pred = 0, target = 0x80 -> next cycle redirect_valid = 1, redirect_pc = 0x80, counter 01->10. if_pc = 0x100 then predicts 1; mispredict_count = 1.
- Four consecutive taken resolves at 0x200 -> counter saturates at 11. One not-taken resolve (pred = 1) -> counter 10, redirect_pc = 0x204, prediction still 1.
- ex_stall = 1 for 3 cycles with a mispredicting branch in EX -> no redirect and no count change. Stall drops -> exactly one redirect; branch_count += 1.
- Cycle after a redirect, EX holds a valid mispredicting branch -> ignored: no second redirect, counters unchanged.
- Preload branch_count = 0xFFFF_FFFF via force, then resolve -> stays 0xFFFF_FFFF. Separately, ex_pc = 0xFFFF_FFFC not-taken mispredict -> redirect_pc = 0x0000_0000.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the branch predictor slice.
//   bht_ctr_t   : 2-bit saturating counter held in each BHT entry
//   BHT_*       : named counter states (strongly/weakly not-taken/taken)
//   bht_next()  : saturating counter update
//   rv32i_word / rv32i_opcode_t : common RV32I datapath types
package branch_predictor_pkg;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } rv32i_opcode_t;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_SNT = 2'b00;
  localparam bht_ctr_t BHT_WNT = 2'b01;
  localparam bht_ctr_t BHT_WT  = 2'b10;
  localparam bht_ctr_t BHT_ST  = 2'b11;

  function automatic bht_ctr_t bht_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != BHT_ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != BHT_SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_bht_array.sv
// Branch history table: 2**IDX_BITS saturating 2-bit counters.
//   clk, rst_n : clock, async active-low reset (all entries -> CTR_INIT)
//   i_rd_idx   : async read index
//   o_rd_ctr   : counter at i_rd_idx (pre-update value on same-cycle write)
//   i_wr_idx   : entry to train
//   i_we       : train enable
//   i_taken    : training direction
module bht_array
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_BITS = 6,
  parameter bht_ctr_t    CTR_INIT = BHT_WNT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] i_rd_idx,
  output bht_ctr_t            o_rd_ctr,
  input  logic [IDX_BITS-1:0] i_wr_idx,
  input  logic                i_we,
  input  logic                i_taken
);

  localparam int unsigned DEPTH = 1 << IDX_BITS;

  bht_ctr_t r_ctr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_ctr[i] <= CTR_INIT;
    end else if (i_we) begin
      r_ctr[i_wr_idx] <= bht_next(r_ctr[i_wr_idx], i_taken);
    end
  end

  assign o_rd_ctr = r_ctr[i_rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor with mispredict redirect and perf counters.
//   clk, rst_n        : clock, async active-low reset
//   if_pc             : fetch PC; if_pred_taken is its prediction
//   ex_valid/ex_is_branch/ex_stall : qualify resolution of the EX branch
//   ex_pc/ex_target   : branch PC and taken target
//   ex_br_en          : actual outcome; ex_pred_taken : prediction it was fetched with
//   redirect_valid/redirect_pc : registered one-cycle fetch redirect
//   branch_count/mispredict_count : saturating perf counters
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_BITS = 6,
  parameter bht_ctr_t    CTR_INIT = BHT_WNT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_stall,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_br_en,
  input  logic        ex_pred_taken,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  logic      r_redirect_valid;
  rv32i_word r_redirect_pc;
  logic [31:0] r_branch_count;
  logic [31:0] r_mispredict_count;

  logic     w_resolve;
  logic     w_mispredict;
  bht_ctr_t w_rd_ctr;
  logic     w_unused_if_pc;

  // EX during a redirect cycle is wrong-path, so it must not resolve.
  assign w_resolve    = ex_valid & ex_is_branch & ~ex_stall & ~r_redirect_valid;
  assign w_mispredict = w_resolve & (ex_br_en != ex_pred_taken);

  assign w_unused_if_pc = ^{if_pc[31:IDX_BITS+2], if_pc[1:0]};

  bht_array #(
    .IDX_BITS (IDX_BITS),
    .CTR_INIT (CTR_INIT)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_rd_idx (if_pc[IDX_BITS+1:2]),
    .o_rd_ctr (w_rd_ctr),
    .i_wr_idx (ex_pc[IDX_BITS+1:2]),
    .i_we     (w_resolve),
    .i_taken  (ex_br_en)
  );

  assign if_pred_taken = w_rd_ctr[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect_valid   <= 1'b0;
      r_redirect_pc      <= '0;
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      r_redirect_valid <= w_mispredict;
      if (w_mispredict) r_redirect_pc <= ex_br_en ? ex_target : ex_pc + 32'd4;
      if (w_resolve && (r_branch_count != '1)) r_branch_count <= r_branch_count + 32'd1;
      if (w_mispredict && (r_mispredict_count != '1))
        r_mispredict_count <= r_mispredict_count + 32'd1;
    end
  end

  assign redirect_valid   = r_redirect_valid;
  assign redirect_pc      = r_redirect_pc;
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int unsigned IDX_BITS = 6;
  localparam int unsigned DEPTH    = 1 << IDX_BITS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] if_pc = '0;
  logic        if_pred_taken;
  logic        ex_valid = 1'b0;
  logic        ex_is_branch = 1'b0;
  logic        ex_stall = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_target = '0;
  logic        ex_br_en = 1'b0;
  logic        ex_pred_taken = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  branch_predictor #(
    .IDX_BITS (IDX_BITS),
    .CTR_INIT (2'b01)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .ex_valid         (ex_valid),
    .ex_is_branch     (ex_is_branch),
    .ex_stall         (ex_stall),
    .ex_pc            (ex_pc),
    .ex_target        (ex_target),
    .ex_br_en         (ex_br_en),
    .ex_pred_taken    (ex_pred_taken),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t        sb_q[$];
  logic [1:0]  m_ctr [DEPTH];
  logic        m_rv;
  logic [31:0] m_rpc, m_bc, m_mc;
  int          n_pass  = 0;
  int          n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return int'((pc >> 2) & (DEPTH - 1));
  endfunction

  function automatic logic m_pred(input logic [31:0] pc);
    logic [1:0] c;
    c = m_ctr[idx_of(pc)];
    return c[1];
  endfunction

  task automatic model_reset();
    for (int unsigned i = 0; i < DEPTH; i++) m_ctr[i] = 2'b01;
    m_rv = 1'b0; m_rpc = '0; m_bc = '0; m_mc = '0;
  endtask

  // Drive one EX cycle, push the expected post-edge state, then compare.
  task automatic step(input string tag, input logic v, input logic b, input logic s,
                      input logic [31:0] pc, input logic [31:0] tgt,
                      input logic en, input logic pred);
    logic res, mp;
    int unsigned k;
    exp_t e, o;
    ex_valid = v; ex_is_branch = b; ex_stall = s; ex_pc = pc;
    ex_target = tgt; ex_br_en = en; ex_pred_taken = pred;
    res = v & b & ~s & ~m_rv;
    mp  = res & (en != pred);
    if (res) begin
      k = idx_of(pc);
      if (en && m_ctr[k] != 2'b11) m_ctr[k] = m_ctr[k] + 2'd1;
      else if (!en && m_ctr[k] != 2'b00) m_ctr[k] = m_ctr[k] - 2'd1;
      if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
      if (mp && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
    end
    if (mp) m_rpc = en ? tgt : pc + 32'd4;
    m_rv = mp;
    e.tag = tag; e.rv = m_rv; e.rpc = m_rpc; e.bc = m_bc; e.mc = m_mc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    chk({o.tag, ".rv"},  {31'b0, redirect_valid}, {31'b0, o.rv});
    chk({o.tag, ".rpc"}, redirect_pc, o.rpc);
    chk({o.tag, ".bc"},  branch_count, o.bc);
    chk({o.tag, ".mc"},  mispredict_count, o.mc);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic chk_pred(input string tag, input logic [31:0] pc);
    if_pc = pc;
    #1;
    chk(tag, {31'b0, if_pred_taken}, {31'b0, m_pred(pc)});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    if_pc = 32'h100;
    #12;
    chk("rst.pred", {31'b0, if_pred_taken}, 32'd0);
    chk("rst.rv",   {31'b0, redirect_valid}, 32'd0);
    chk("rst.rpc",  redirect_pc, 32'd0);
    chk("rst.bc",   branch_count, 32'd0);
    chk("rst.mc",   mispredict_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Taken mispredict at 0x100 -> redirect to target, counter 01->10.
    step("t1", 1, 1, 0, 32'h100, 32'h80, 1, 0);
    chk("t1.rpc_const", redirect_pc, 32'h80);
    chk_pred("t1.pred", 32'h100);
    chk("t1.pred_const", {31'b0, if_pred_taken}, 32'd1);
    idle("t1.idle");

    // 0x200 aliases 0x100 (same index); saturate then one not-taken.
    for (int i = 0; i < 4; i++) begin
      step("sat", 1, 1, 0, 32'h200, 32'h40, 1, m_pred(32'h200));
      if (m_rv) idle("sat.idle");
    end
    step("nt", 1, 1, 0, 32'h200, 32'h40, 0, 1);
    chk("nt.rpc_const", redirect_pc, 32'h204);
    chk_pred("nt.pred", 32'h200);
    chk("nt.pred_const", {31'b0, if_pred_taken}, 32'd1);
    chk_pred("alias.pred", 32'h103);
    idle("nt.idle");

    // Non-branch and invalid instructions change nothing.
    step("nonbr", 1, 0, 0, 32'h104, 32'h999, 1, 0);
    step("inval", 0, 1, 0, 32'h104, 32'h999, 1, 0);

    // Stalled mispredicting branch resolves once after the stall; the
    // following cycle it is still in EX but wrong-path.
    for (int i = 0; i < 3; i++) step("stall", 1, 1, 1, 32'h30C, 32'h500, 0, 1);
    step("unstall", 1, 1, 0, 32'h30C, 32'h500, 0, 1);
    chk("unstall.rpc_const", redirect_pc, 32'h310);
    step("wrongpath", 1, 1, 0, 32'h30C, 32'h500, 0, 1);
    chk_pred("stall.pred", 32'h30C);
    idle("stall.idle");

    // Same-cycle read/write of one index shows the old value.
    if_pc = 32'h404;
    ex_valid = 1; ex_is_branch = 1; ex_stall = 0; ex_pc = 32'h404; ex_br_en = 1;
    #1;
    chk("bypass.old", {31'b0, if_pred_taken}, 32'd0);
    step("bypass", 1, 1, 0, 32'h404, 32'h600, 1, 0);
    chk_pred("bypass.new", 32'h404);
    idle("bypass.idle");

    // Saturating perf counters.
    force dut.r_branch_count = 32'hFFFF_FFFF;
    force dut.r_mispredict_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_branch_count;
    release dut.r_mispredict_count;
    m_bc = 32'hFFFF_FFFF; m_mc = 32'hFFFF_FFFF;
    step("satcnt", 1, 1, 0, 32'h408, 32'h700, 0, 1);
    idle("satcnt.idle");

    // PC+4 wraps at the top of the address space.
    step("wrap", 1, 1, 0, 32'hFFFF_FFFC, 32'h10, 0, 1);
    chk("wrap.rpc_const", redirect_pc, 32'h0);

    // Async reset during a live redirect.
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.rv", {31'b0, redirect_valid}, 32'd0);
    chk("arst.bc", branch_count, 32'd0);
    chk_pred("arst.pred", 32'h200);
    @(negedge clk);
    rst_n = 1'b1;
    idle("arst.idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
